game_controller: RTL and testbench

GAME_CONTROLLER -- requirements
Module: game_controller

---
 rtl/game_pkg.sv | 24 ++
 rtl/game_tick_gen.sv | 21 ++
 rtl/game_controller.sv | 154 +++++++++++++++
 tb/tb_game_controller.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared game-state, phase and move-direction encodings
package game_pkg;
    typedef enum logic [2:0] {
        GS_IDLE  = 3'd0,
        GS_RUN   = 3'd1,
        GS_OVER  = 3'd2,
        GS_ERR   = 3'd3,
        GS_PAUSE = 3'd4
    } game_state_e;
    // PH_WAIT is the sequencer idle slot between ticks; it never reaches phase_id
    typedef enum logic [2:0] {
        PH_PHYS   = 3'd0,
        PH_COLL   = 3'd1,
        PH_VIEW   = 3'd2,
        PH_RENDER = 3'd3,
        PH_WAIT   = 3'd4
    } phase_e;
    localparam logic [1:0] MOVE_NONE  = 2'b00;
    localparam logic [1:0] MOVE_LEFT  = 2'b01;
    localparam logic [1:0] MOVE_RIGHT = 2'b10;
    function automatic logic [1:0] move_enc(input logic l, input logic r);
        return (l && !r) ? MOVE_LEFT : (r && !l) ? MOVE_RIGHT : MOVE_NONE;
    endfunction
endpackage

// File: rtl/game_tick_gen.sv
// game_tick_gen: physics tick divider
// Ports: clk, reset (sync, active-high); en advances the counter, clr zeroes it;
//        tick_pulse is high on the cycle the counter wraps from TICK_DIV-1.
module game_tick_gen #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick_pulse
);
    localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        tick_pulse = en && cnt_q == LAST;
        cnt_d = clr ? '0 : !en ? cnt_q : tick_pulse ? '0 : cnt_q + 1'b1;
    end
    always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
endmodule

// File: rtl/game_controller.sv
// game_controller: top game FSM sequencing physics/collision/view/render phases
// Ports: clk, reset (sync, active-high); btn_left/right/start player buttons;
//        phase_req/phase_id/phase_done phase handshake; doodle_y/min_y heights;
//        move_dir latched intent; score best min_y; game_state; frame_strobe.
// Build option: GAME_CONTROLLER_PAUSE_EN enables start-button pause in RUN.
// Assumes COORD_W >= SCORE_W; height comparisons are unsigned.
module game_controller
    import game_pkg::*;
#(
    parameter int TICK_DIV      = 4,
    parameter int COORD_W       = 32,
    parameter int SCORE_W       = 16,
    parameter int PHASE_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_start,
    output logic               phase_req,
    output logic [2:0]         phase_id,
    input  logic               phase_done,
    output logic [1:0]         move_dir,
    input  logic [COORD_W-1:0] doodle_y,
    input  logic [COORD_W-1:0] min_y,
    output logic [SCORE_W-1:0] score,
    output logic [2:0]         game_state,
    output logic               frame_strobe
);
    localparam int TW = $clog2(PHASE_TIMEOUT + 2);
    game_state_e state_q, state_d;
    phase_e phase_q, phase_d;
    logic phase_req_q, phase_req_d, frame_strobe_q, frame_strobe_d;
    logic overrun_q, overrun_d, start_prev_q, start_edge, done_ok, tick_pulse;
    logic [2:0] phase_id_q, phase_id_d;
    logic [1:0] move_dir_q, move_dir_d;
    logic [SCORE_W-1:0] score_q, score_d, min_sat;
    logic [TW-1:0] timeout_q, timeout_d;
`ifdef GAME_CONTROLLER_PAUSE_EN
    logic pause_pend_q, pause_pend_d;
`endif
    game_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk(clk),
        .reset(reset),
        .en(state_q == GS_RUN),
        .clr(state_q == GS_IDLE && start_edge),
        .tick_pulse(tick_pulse)
    );
    always_comb begin
        start_edge = btn_start && !start_prev_q;
        done_ok = phase_req_q && phase_done;
        // heights above the score range clamp to all-ones instead of wrapping
        min_sat = (|(min_y >> SCORE_W)) ? '1 : min_y[SCORE_W-1:0];
        state_d = state_q;
        phase_d = phase_q;
        phase_req_d = 1'b0;
        phase_id_d = phase_id_q;
        move_dir_d = move_dir_q;
        score_d = score_q;
        frame_strobe_d = 1'b0;
        timeout_d = '0;
        overrun_d = overrun_q;
`ifdef GAME_CONTROLLER_PAUSE_EN
        pause_pend_d = pause_pend_q;
`endif
        case (state_q)
            GS_IDLE: if (start_edge) begin
                state_d = GS_RUN;
                score_d = '0;
                phase_d = PH_WAIT;
            end
            GS_RUN: if (phase_q == PH_WAIT) begin
`ifdef GAME_CONTROLLER_PAUSE_EN
                if (pause_pend_q || start_edge) begin
                    state_d = GS_PAUSE;
                    pause_pend_d = 1'b0;
                end else
`endif
                if (tick_pulse) begin
                    phase_d = PH_PHYS;
                    phase_id_d = PH_PHYS;
                    move_dir_d = move_enc(btn_left, btn_right);
                end
            end else begin
`ifdef GAME_CONTROLLER_PAUSE_EN
                if (start_edge) pause_pend_d = 1'b1;
`endif
                if (tick_pulse) overrun_d = 1'b1;
                if (done_ok) begin
                    if (phase_q == PH_VIEW) score_d = min_sat > score_q ? min_sat : score_q;
                    if (phase_q == PH_RENDER) begin
                        phase_d = PH_WAIT;
                        frame_strobe_d = 1'b1;
                    end else if (phase_q == PH_VIEW && doodle_y < min_y) begin
                        state_d = GS_OVER;
                        phase_d = PH_WAIT;
                    end else begin
                        phase_d = phase_e'(phase_q + 3'd1);
                        phase_id_d = phase_d;
                    end
                end else if (phase_req_q && timeout_q >= TW'(PHASE_TIMEOUT)) begin
                    state_d = GS_ERR;
                    phase_d = PH_WAIT;
                end else begin
                    // request is held low on the entry cycle, so it rises one cycle later
                    phase_req_d = 1'b1;
                    timeout_d = phase_req_q ? timeout_q + 1'b1 : '0;
                end
            end
`ifdef GAME_CONTROLLER_PAUSE_EN
            GS_PAUSE: if (start_edge) state_d = GS_RUN;
`endif
            GS_OVER: if (start_edge) state_d = GS_IDLE;
            default: ;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= GS_IDLE;
            phase_q <= PH_WAIT;
            phase_req_q <= 1'b0;
            phase_id_q <= 3'd0;
            move_dir_q <= MOVE_NONE;
            score_q <= '0;
            frame_strobe_q <= 1'b0;
            timeout_q <= '0;
            overrun_q <= 1'b0;
            start_prev_q <= 1'b0;
`ifdef GAME_CONTROLLER_PAUSE_EN
            pause_pend_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            phase_req_q <= phase_req_d;
            phase_id_q <= phase_id_d;
            move_dir_q <= move_dir_d;
            score_q <= score_d;
            frame_strobe_q <= frame_strobe_d;
            timeout_q <= timeout_d;
            overrun_q <= overrun_d;
            start_prev_q <= btn_start;
`ifdef GAME_CONTROLLER_PAUSE_EN
            pause_pend_q <= pause_pend_d;
`endif
        end
    end
    assign phase_req = phase_req_q;
    assign phase_id = phase_id_q;
    assign move_dir = move_dir_q;
    assign score = score_q;
    assign game_state = state_q;
    assign frame_strobe = frame_strobe_q;
endmodule

// File: tb/tb_game_controller.sv
// tb_game_controller: directed self-checking bench for game_controller
module tb_game_controller;
    logic clk = 1'b0, reset = 1'b1;
    logic btn_left = 1'b0, btn_right = 1'b0, btn_start = 1'b0, phase_done = 1'b0;
    logic [31:0] doodle_y = '0, min_y = '0;
    logic phase_req, frame_strobe, phase_req4, frame_strobe4;
    logic [2:0] phase_id, game_state, phase_id4, game_state4;
    logic [1:0] move_dir, move_dir4;
    logic [15:0] score;
    logic [3:0] score4;
    int checks = 0, errors = 0;
    always #5 clk = ~clk;
    game_controller #(.TICK_DIV(4), .COORD_W(32), .SCORE_W(16), .PHASE_TIMEOUT(255)) dut (
        .clk(clk), .reset(reset), .btn_left(btn_left), .btn_right(btn_right),
        .btn_start(btn_start), .phase_req(phase_req), .phase_id(phase_id),
        .phase_done(phase_done), .move_dir(move_dir), .doodle_y(doodle_y),
        .min_y(min_y), .score(score), .game_state(game_state), .frame_strobe(frame_strobe)
    );
    game_controller #(.TICK_DIV(4), .COORD_W(32), .SCORE_W(4), .PHASE_TIMEOUT(255)) dut4 (
        .clk(clk), .reset(reset), .btn_left(btn_left), .btn_right(btn_right),
        .btn_start(btn_start), .phase_req(phase_req4), .phase_id(phase_id4),
        .phase_done(phase_done), .move_dir(move_dir4), .doodle_y(doodle_y),
        .min_y(min_y), .score(score4), .game_state(game_state4), .frame_strobe(frame_strobe4)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic wait_req();
        int n = 0;
        while (!phase_req && n < 20) begin
            step();
            n++;
        end
        check("req_wait", {31'd0, phase_req}, 1);
    endtask
    task automatic frame(input logic [1:0] mv, input logic [31:0] dy, input logic [31:0] my,
                         input logic [15:0] sc, input logic over, input logic nl, input logic nr);
        doodle_y = dy;
        min_y = my;
        for (int p = 0; p < 4; p++) begin
            wait_req();
            check("phase_id", {29'd0, phase_id}, p);
            check("move_dir", {30'd0, move_dir}, {30'd0, mv});
            if (p == 0) begin
                btn_left = ~btn_left;
                btn_right = ~btn_right;
            end
            step();
            step();
            phase_done = 1'b1;
            if (p == 3) begin
                btn_left = nl;
                btn_right = nr;
            end
            step();
            phase_done = 1'b0;
            check("req_drop", {31'd0, phase_req}, 0);
            check("strobe", {31'd0, frame_strobe}, (p == 3) ? 1 : 0);
            if (p == 2) begin
                check("score", {16'd0, score}, {16'd0, sc});
                check("state_view", {29'd0, game_state}, over ? 2 : 1);
                if (over) return;
            end
        end
        step();
        check("strobe_low", {31'd0, frame_strobe}, 0);
    endtask
    initial begin
        int bad;
        repeat (3) step();
        reset = 1'b0;
        check("rst_state", {29'd0, game_state}, 0);
        check("rst_req", {31'd0, phase_req}, 0);
        check("rst_id", {29'd0, phase_id}, 0);
        check("rst_move", {30'd0, move_dir}, 0);
        check("rst_score", {16'd0, score}, 0);
        check("rst_strobe", {31'd0, frame_strobe}, 0);
        repeat (10) step();
        check("idle_no_req", {31'd0, phase_req}, 0);
        btn_left = 1'b1;
        btn_right = 1'b0;
        btn_start = 1'b1;
        step();
        check("to_run", {29'd0, game_state}, 1);
        frame(2'b01, 100, 7, 7, 1'b0, 1'b1, 1'b1);
        check("score4_a", {28'd0, score4}, 7);
        btn_start = 1'b0;
        frame(2'b00, 100, 3, 7, 1'b0, 1'b0, 1'b1);
        frame(2'b10, 100, 20, 20, 1'b0, 1'b0, 1'b0);
        check("score4_sat", {28'd0, score4}, 15);
        frame(2'b00, 5, 9, 20, 1'b1, 1'b0, 1'b0);
        check("over_req", {31'd0, phase_req}, 0);
        repeat (20) step();
        check("over_hold", {29'd0, game_state}, 2);
        check("over_req2", {31'd0, phase_req}, 0);
        btn_start = 1'b1;
        step();
        check("to_idle", {29'd0, game_state}, 0);
        repeat (3) step();
        check("held_start", {29'd0, game_state}, 0);
        btn_start = 1'b0;
        btn_left = 1'b0;
        btn_right = 1'b1;
        step();
        btn_start = 1'b1;
        step();
        btn_start = 1'b0;
        check("rerun", {29'd0, game_state}, 1);
        check("score_clr", {16'd0, score}, 0);
        check("score4_clr", {28'd0, score4}, 0);
        wait_req();
        check("to_move", {30'd0, move_dir}, 2);
        repeat (255) step();
        check("to_wait_state", {29'd0, game_state}, 1);
        check("to_wait_req", {31'd0, phase_req}, 1);
        step();
        check("to_err", {29'd0, game_state}, 3);
        check("err_req", {31'd0, phase_req}, 0);
        phase_done = 1'b1;
        step();
        phase_done = 1'b0;
        step();
        check("err_stuck", {29'd0, game_state}, 3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        phase_done = 1'b1;
        step();
        phase_done = 1'b0;
        check("rst2_state", {29'd0, game_state}, 0);
        check("rst2_req", {31'd0, phase_req}, 0);
        check("rst2_id", {29'd0, phase_id}, 0);
        check("rst2_move", {30'd0, move_dir}, 0);
        check("rst2_score", {16'd0, score}, 0);
        check("rst2_strobe", {31'd0, frame_strobe}, 0);
        btn_left = 1'b1;
        btn_right = 1'b0;
        btn_start = 1'b1;
        step();
        btn_start = 1'b0;
        wait_req();
        btn_start = 1'b1;
        step();
        btn_start = 1'b0;
        step();
        frame(2'b01, 100, 4, 4, 1'b0, 1'b0, 1'b0);
        bad = 0;
`ifdef GAME_CONTROLLER_PAUSE_EN
        check("pause_enter", {29'd0, game_state}, 4);
        repeat (20) begin
            step();
            if (phase_req || game_state != 3'd4) bad++;
        end
        check("pause_hold", bad, 0);
        btn_start = 1'b1;
        step();
        btn_start = 1'b0;
        check("pause_exit", {29'd0, game_state}, 1);
`else
        check("no_pause", {29'd0, game_state}, 1);
        repeat (20) begin
            step();
            if (game_state != 3'd1) bad++;
        end
        check("run_hold", bad, 0);
`endif
        wait_req();
        check("resume_phys", {29'd0, phase_id}, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
